freq_from_period: RTL



---
 rtl/freq_from_period.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/freq_from_period.sv
// Converts an averaged period count into a rounded frequency in Hz using a
// multi-cycle restoring divider (one quotient bit per clock).
module freq_from_period #(
    parameter int CLK_FREQ      = 200_000_000,
    parameter int COUNTER_WIDTH = 18,
    parameter int FREQ_WIDTH    = 28,
    parameter int MIN_PERIOD    = 2000,
    parameter int MAX_PERIOD    = 200000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COUNTER_WIDTH-1:0] period,
    input  logic                     stable,
    output logic [FREQ_WIDTH-1:0]    freq_hz,
    output logic                     freq_valid,
    output logic                     update,
    output logic                     busy,
    output logic                     out_of_range
);

    localparam int REM_W = COUNTER_WIDTH + 1;
    localparam int CNT_W = $clog2(FREQ_WIDTH);
    localparam logic [FREQ_WIDTH-1:0] DIVIDEND_BASE = FREQ_WIDTH'(CLK_FREQ);
    localparam logic [CNT_W-1:0]      CNT_START     = CNT_W'(FREQ_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [COUNTER_WIDTH-1:0] divisor_r;
    logic [COUNTER_WIDTH-1:0] last_period_r;
    logic [FREQ_WIDTH-1:0]    dividend_r;
    logic [REM_W-1:0]         rem_r;
    logic [CNT_W-1:0]         cnt_r;

    logic                     in_range_s;
    logic                     start_s;
    logic [REM_W-1:0]         rem_shift_s;
    logic                     sub_ok_s;

    assign in_range_s  = (period >= COUNTER_WIDTH'(MIN_PERIOD)) &&
                         (period <= COUNTER_WIDTH'(MAX_PERIOD));
    assign start_s     = stable && in_range_s && (!freq_valid || (period != last_period_r));
    assign rem_shift_s = {rem_r[REM_W-2:0], dividend_r[FREQ_WIDTH-1]};
    assign sub_ok_s    = (rem_shift_s >= {1'b0, divisor_r});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; losing stable aborts any conversion in flight
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_next_s = DIVIDE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIVIDE: begin
                if (!stable) begin
                    state_next_s = IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DIVIDE;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Divider datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_hz       <= {FREQ_WIDTH{1'b0}};
            freq_valid    <= 1'b0;
            update        <= 1'b0;
            busy          <= 1'b0;
            out_of_range  <= 1'b0;
            divisor_r     <= {COUNTER_WIDTH{1'b0}};
            last_period_r <= {COUNTER_WIDTH{1'b0}};
            dividend_r    <= {FREQ_WIDTH{1'b0}};
            rem_r         <= {REM_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
        end else begin
            out_of_range <= stable && !in_range_s;
            busy         <= (state_next_s != IDLE);
            update       <= 1'b0;
            if (!stable) begin
                freq_valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        divisor_r     <= period;
                        last_period_r <= period;
                        // half-divisor bias rounds to nearest, ties up
                        dividend_r    <= DIVIDEND_BASE + FREQ_WIDTH'(period >> 1);
                        rem_r         <= {REM_W{1'b0}};
                        cnt_r         <= CNT_START;
                    end else if (stable && !in_range_s) begin
                        freq_valid <= 1'b0;
                    end
                end
                DIVIDE: begin
                    // quotient bits shift into the vacated dividend LSBs
                    if (sub_ok_s) begin
                        rem_r      <= rem_shift_s - {1'b0, divisor_r};
                        dividend_r <= {dividend_r[FREQ_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r      <= rem_shift_s;
                        dividend_r <= {dividend_r[FREQ_WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r - 1'b1;
                end
                DONE: begin
                    if (stable) begin
                        freq_hz    <= dividend_r;
                        freq_valid <= 1'b1;
                        update     <= 1'b1;
                    end
                end
                default: begin
                    freq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
